// File: rtl/sram_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : sram_axi_bridge
// Purpose  : Converts the CPU core's two SRAM-like request/addr_ok/data_ok
//            interfaces (instruction fetch, data access) into one AXI master.
//            One read and one write may be outstanding at the same time.
//            The data port wins read arbitration, and only the data port
//            writes. A data read is held off while a write is outstanding,
//            and a data write is held off while a data read is outstanding,
//            so a read never overtakes a write to the same location.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, resetn             clock, asynchronous active-low reset
//   inst_sram_*             instruction SRAM-like port (reads only)
//   data_sram_*             data SRAM-like port (reads and writes)
//     *_req/_wr/_size/_addr/_wstrb/_wdata   request fields from the core
//     *_addr_ok             request accepted this cycle (combinational)
//     *_data_ok, *_rdata    one-cycle completion pulse, read data
//   ar*  (arid, araddr, arsize, arvalid, arready)   AXI read address
//   r*   (rid, rdata, rvalid, rready)               AXI read data
//   aw*  (awaddr, awsize, awvalid, awready)         AXI write address
//   w*   (wdata, wstrb, wvalid, wready)             AXI write data
//   b*   (bvalid, bready)                           AXI write response
//   Fixed AXI fields (len, burst, lock, cache, prot, wid, wlast) are tied
//   off by the parent.
// ============================================================================
module sram_axi_bridge #(
  parameter logic [3:0] ID_INST = 4'd0,
  parameter logic [3:0] ID_DATA = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,

  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,

  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,

  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,

  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_AR   = 2'd1,
    RD_R    = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_REQ  = 2'd1,
    WR_B    = 2'd2
  } wr_state_t;

  rd_state_t   r_rd_state;
  rd_state_t   w_rd_next;
  wr_state_t   r_wr_state;
  wr_state_t   w_wr_next;

  logic [31:0] r_araddr;
  logic [2:0]  r_arsize;
  logic [3:0]  r_arid;

  logic [31:0] r_awaddr;
  logic [2:0]  r_awsize;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;
  logic        r_aw_pend;
  logic        r_w_pend;

  logic        w_rd_idle;
  logic        w_wr_idle;
  logic        w_data_rd_win;
  logic        w_inst_rd_win;
  logic        w_data_wr_win;
  logic        w_r_fire;
  logic        w_b_fire;

  // The instruction port is read-only; its write-side fields carry no meaning.
  logic        w_unused_inst_wr_fields;
  assign w_unused_inst_wr_fields = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata};

  assign w_rd_idle = (r_rd_state == RD_IDLE);
  assign w_wr_idle = (r_wr_state == WR_IDLE);

  // --------------------------------------------------------------------------
  // Request arbitration. The resetn term keeps addr_ok low while reset is
  // held, since both FSMs sit in IDLE then and would otherwise accept.
  // --------------------------------------------------------------------------
  // Data read: only when no write is in flight (read-after-write ordering).
  assign w_data_rd_win = resetn & data_sram_req & ~data_sram_wr & w_rd_idle & w_wr_idle;

  // Instruction read: only when the data port is not taking the read channel.
  assign w_inst_rd_win = resetn & inst_sram_req & w_rd_idle & ~w_data_rd_win;

  // Data write: blocked only by an outstanding read belonging to the data port.
  // When the read FSM is idle, r_arid may still hold a stale ID_DATA, hence
  // the idle term in the OR.
  assign w_data_wr_win = resetn & data_sram_req & data_sram_wr & w_wr_idle &
                         (w_rd_idle | (r_arid != ID_DATA));

  assign inst_sram_addr_ok = w_inst_rd_win;
  assign data_sram_addr_ok = w_data_rd_win | w_data_wr_win;

  // --------------------------------------------------------------------------
  // Read FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_state <= RD_IDLE;
    end else begin
      r_rd_state <= w_rd_next;
    end
  end

  always_comb begin
    w_rd_next = r_rd_state;
    arvalid   = 1'b0;
    rready    = 1'b0;
    w_r_fire  = 1'b0;
    case (r_rd_state)
      RD_IDLE: begin
        if (w_data_rd_win || w_inst_rd_win) begin
          w_rd_next = RD_AR;
        end
      end
      RD_AR: begin
        arvalid = 1'b1;
        if (arready) begin
          w_rd_next = RD_R;
        end
      end
      RD_R: begin
        rready = 1'b1;
        if (rvalid) begin
          w_r_fire  = 1'b1;
          w_rd_next = RD_IDLE;
        end
      end
      default: begin
        w_rd_next = RD_IDLE;
      end
    endcase
  end

  // Read request fields are captured on acceptance and held until the next
  // acceptance, so they stay stable across every arvalid cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_araddr <= 32'd0;
      r_arsize <= 3'd0;
      r_arid   <= 4'd0;
    end else if (w_data_rd_win) begin
      r_araddr <= data_sram_addr;
      r_arsize <= {1'b0, data_sram_size};
      r_arid   <= ID_DATA;
    end else if (w_inst_rd_win) begin
      r_araddr <= inst_sram_addr;
      r_arsize <= {1'b0, inst_sram_size};
      r_arid   <= ID_INST;
    end
  end

  assign arid   = r_arid;
  assign araddr = r_araddr;
  assign arsize = r_arsize;

  // --------------------------------------------------------------------------
  // Write FSM. AW and W are independent channels: each pending flag drops on
  // its own handshake, and the response phase starts once both have gone.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_state <= WR_IDLE;
    end else begin
      r_wr_state <= w_wr_next;
    end
  end

  always_comb begin
    w_wr_next = r_wr_state;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    w_b_fire  = 1'b0;
    case (r_wr_state)
      WR_IDLE: begin
        if (w_data_wr_win) begin
          w_wr_next = WR_REQ;
        end
      end
      WR_REQ: begin
        awvalid = r_aw_pend;
        wvalid  = r_w_pend;
        if ((!r_aw_pend || awready) && (!r_w_pend || wready)) begin
          w_wr_next = WR_B;
        end
      end
      WR_B: begin
        bready = 1'b1;
        if (bvalid) begin
          w_b_fire  = 1'b1;
          w_wr_next = WR_IDLE;
        end
      end
      default: begin
        w_wr_next = WR_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_awaddr  <= 32'd0;
      r_awsize  <= 3'd0;
      r_wstrb   <= 4'd0;
      r_wdata   <= 32'd0;
      r_aw_pend <= 1'b0;
      r_w_pend  <= 1'b0;
    end else if (w_data_wr_win) begin
      r_awaddr  <= data_sram_addr;
      r_awsize  <= {1'b0, data_sram_size};
      r_wstrb   <= data_sram_wstrb;
      r_wdata   <= data_sram_wdata;
      r_aw_pend <= 1'b1;
      r_w_pend  <= 1'b1;
    end else if (r_wr_state == WR_REQ) begin
      // Ready inputs are only meaningful while the request phase is active.
      if (awready) begin
        r_aw_pend <= 1'b0;
      end
      if (wready) begin
        r_w_pend <= 1'b0;
      end
    end
  end

  assign awaddr = r_awaddr;
  assign awsize = r_awsize;
  assign wdata  = r_wdata;
  assign wstrb  = r_wstrb;

  // --------------------------------------------------------------------------
  // Completion. Read data is steered by rid; an unrecognised rid retires the
  // read silently. A data read and a data write are never outstanding
  // together, so the two sources of data_sram_data_ok cannot collide.
  // --------------------------------------------------------------------------
  assign inst_sram_data_ok = w_r_fire & (rid == ID_INST);
  assign data_sram_data_ok = (w_r_fire & (rid == ID_DATA)) | w_b_fire;

  assign inst_sram_rdata = rdata;
  assign data_sram_rdata = rdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_axi_bridge
// Purpose  : Self-checking bench for sram_axi_bridge. A table of single
//            transactions with slave delays, hand-written sequences for
//            arbitration, ordering, overlap and reset, then randomized
//            concurrent traffic checked against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_axi_bridge;

  localparam logic [3:0] ID_INST = 4'd0;
  localparam logic [3:0] ID_DATA = 4'd1;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid, rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic        bvalid, bready;

  always #5 clk = ~clk;

  sram_axi_bridge #(.ID_INST(ID_INST), .ID_DATA(ID_DATA)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // 4 units after it, well before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic clear_inputs();
    inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'd0;
    inst_sram_addr = 32'd0; inst_sram_wstrb = 4'd0; inst_sram_wdata = 32'd0;
    data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd0;
    data_sram_addr = 32'd0; data_sram_wstrb = 4'd0; data_sram_wdata = 32'd0;
    arready = 1'b0; rid = 4'd0; rdata = 32'd0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
  endtask

  task automatic chk_quiet(input string name);
    chk1({name, " arvalid"}, arvalid, 1'b0);
    chk1({name, " rready"},  rready,  1'b0);
    chk1({name, " awvalid"}, awvalid, 1'b0);
    chk1({name, " wvalid"},  wvalid,  1'b0);
    chk1({name, " bready"},  bready,  1'b0);
    chk1({name, " inst data_ok"}, inst_sram_data_ok, 1'b0);
    chk1({name, " data data_ok"}, data_sram_data_ok, 1'b0);
  endtask

  // kind: 0 = inst read, 1 = data read, 2 = data write
  typedef struct {
    int          kind;
    logic        iwr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    int          dly_a;     // arready / awready wait cycles
    int          dly_w;     // wready wait cycles
    int          dly_r;     // rvalid / bvalid wait cycles
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [3:0]  exp_id;
    logic [2:0]  exp_size;
    logic        exp_iok;
    logic        exp_dok;
  } txn_t;

  task automatic run_txn(input txn_t t);
    bit aw_p, w_p;
    int c;
    if (t.kind == 0) begin
      inst_sram_req = 1'b1; inst_sram_wr = t.iwr; inst_sram_addr = t.addr;
      inst_sram_size = t.size; inst_sram_wstrb = t.wstrb; inst_sram_wdata = t.wdata;
    end else begin
      data_sram_req = 1'b1; data_sram_wr = (t.kind == 2); data_sram_addr = t.addr;
      data_sram_size = t.size; data_sram_wstrb = t.wstrb; data_sram_wdata = t.wdata;
    end
    settle();
    chk1("txn inst addr_ok", inst_sram_addr_ok, t.kind == 0);
    chk1("txn data addr_ok", data_sram_addr_ok, t.kind != 0);
    if (t.kind != 2) begin
      for (int i = 0; i <= t.dly_a; i++) begin
        tick();
        inst_sram_req = 1'b0; data_sram_req = 1'b0;
        arready = (i == t.dly_a);
        settle();
        chk1("txn arvalid", arvalid, 1'b1);
        chk32("txn araddr", araddr, t.addr);
        chk32("txn arsize", 32'(arsize), 32'(t.exp_size));
        chk32("txn arid", 32'(arid), 32'(t.exp_id));
        chk1("txn addr_ok while busy", inst_sram_addr_ok | data_sram_addr_ok, 1'b0);
      end
      for (int i = 0; i <= t.dly_r; i++) begin
        tick();
        arready = 1'b0; rvalid = (i == t.dly_r); rid = t.rid; rdata = t.rdata;
        settle();
        chk1("txn rready", rready, 1'b1);
        chk1("txn inst data_ok", inst_sram_data_ok, rvalid && t.exp_iok);
        chk1("txn data data_ok", data_sram_data_ok, rvalid && t.exp_dok);
        if (rvalid && t.exp_iok) chk32("txn inst rdata", inst_sram_rdata, t.rdata);
        if (rvalid && t.exp_dok) chk32("txn data rdata", data_sram_rdata, t.rdata);
      end
    end else begin
      aw_p = 1'b1; w_p = 1'b1; c = 0;
      while ((aw_p || w_p) && c < 16) begin
        tick();
        data_sram_req = 1'b0;
        awready = aw_p && (c >= t.dly_a);
        wready  = w_p && (c >= t.dly_w);
        settle();
        chk1("txn awvalid", awvalid, aw_p);
        chk1("txn wvalid", wvalid, w_p);
        if (aw_p) begin
          chk32("txn awaddr", awaddr, t.addr);
          chk32("txn awsize", 32'(awsize), 32'(t.exp_size));
        end
        if (w_p) begin
          chk32("txn wdata", wdata, t.wdata);
          chk32("txn wstrb", 32'(wstrb), 32'(t.wstrb));
        end
        chk1("txn early data_ok", data_sram_data_ok, 1'b0);
        if (awready) aw_p = 1'b0;
        if (wready)  w_p  = 1'b0;
        c++;
      end
      if (aw_p || w_p) chk1("txn write handshake bound", 1'b0, 1'b1);
      for (int i = 0; i <= t.dly_r; i++) begin
        tick();
        awready = 1'b0; wready = 1'b0; bvalid = (i == t.dly_r);
        settle();
        chk1("txn bready", bready, 1'b1);
        chk1("txn write data_ok", data_sram_data_ok, bvalid && t.exp_dok);
        chk1("txn write inst data_ok", inst_sram_data_ok, 1'b0);
      end
    end
    tick();
    rvalid = 1'b0; bvalid = 1'b0;
    settle();
    chk_quiet("txn end");
  endtask

  // Transaction-level model state for the random phase.
  bit          m_rd_busy, m_ar_done, m_wr_busy, m_aw_done, m_w_done;
  logic [31:0] m_rd_addr, m_wr_addr, m_wr_data;
  logic [2:0]  m_rd_size, m_wr_size;
  logic [3:0]  m_rd_id, m_wr_strb;

  txn_t tbl[7];

  initial begin
    bit p_iok, p_dok;
    bit e_drd, e_iok, e_dwr, e_arv, e_rr, e_awv, e_wv, e_br, r_from_dat;

    tbl[0] = '{0, 1'b0, 32'h1c000000, 2'd2, 4'h0, 32'h0, 3, 0, 0, ID_INST, 32'h02800C0C, ID_INST, 3'd2, 1'b1, 1'b0};
    tbl[1] = '{1, 1'b0, 32'h80001002, 2'd1, 4'h0, 32'h0, 0, 0, 2, ID_DATA, 32'hdeadbeef, ID_DATA, 3'd1, 1'b0, 1'b1};
    tbl[2] = '{1, 1'b0, 32'h00000040, 2'd0, 4'h0, 32'h0, 1, 0, 0, 4'h7,    32'h00000055, ID_DATA, 3'd0, 1'b0, 1'b0};
    tbl[3] = '{2, 1'b0, 32'h00001000, 2'd2, 4'b0011, 32'h1234abcd, 0, 2, 1, 4'h0, 32'h0, ID_DATA, 3'd2, 1'b0, 1'b1};
    tbl[4] = '{2, 1'b0, 32'h00002003, 2'd0, 4'b1000, 32'ha5a5a5a5, 3, 0, 0, 4'h0, 32'h0, ID_DATA, 3'd0, 1'b0, 1'b1};
    tbl[5] = '{2, 1'b0, 32'h00003000, 2'd1, 4'b1100, 32'h00000000, 0, 0, 0, 4'h0, 32'h0, ID_DATA, 3'd1, 1'b0, 1'b1};
    tbl[6] = '{0, 1'b1, 32'h1c000004, 2'd2, 4'hf, 32'hffffffff, 0, 0, 0, ID_INST, 32'h00000013, ID_INST, 3'd2, 1'b1, 1'b0};

    // ---------------- reset state ----------------
    clear_inputs();
    resetn = 1'b1;
    #2 resetn = 1'b0;
    inst_sram_req = 1'b1; data_sram_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset");
    chk1("reset inst addr_ok", inst_sram_addr_ok, 1'b0);
    chk1("reset data addr_ok", data_sram_addr_ok, 1'b0);
    chk32("reset araddr", araddr, 32'd0);
    chk32("reset awaddr", awaddr, 32'd0);
    chk32("reset wdata", wdata, 32'd0);
    inst_sram_req = 1'b0; data_sram_req = 1'b0;
    resetn = 1'b1;
    tick();

    // ---------------- table-driven single transactions ----------------
    foreach (tbl[k]) begin
      run_txn(tbl[k]);
      clear_inputs();
      tick();
    end

    // ---------------- inst and data reads in the same cycle ----------------
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1c000010; inst_sram_size = 2'd2;
    data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h80000020; data_sram_size = 2'd2;
    settle();
    chk1("prio data addr_ok", data_sram_addr_ok, 1'b1);
    chk1("prio inst addr_ok", inst_sram_addr_ok, 1'b0);
    tick(); data_sram_req = 1'b0; arready = 1'b1; settle();
    chk32("prio arid data", 32'(arid), 32'(ID_DATA));
    chk32("prio araddr data", araddr, 32'h80000020);
    chk1("prio inst held AR", inst_sram_addr_ok, 1'b0);
    tick(); arready = 1'b0; rvalid = 1'b1; rid = ID_DATA; rdata = 32'hcafef00d; settle();
    chk1("prio data data_ok", data_sram_data_ok, 1'b1);
    chk32("prio data rdata", data_sram_rdata, 32'hcafef00d);
    chk1("prio inst held R", inst_sram_addr_ok, 1'b0);
    tick(); rvalid = 1'b0; settle();
    chk1("prio inst addr_ok after", inst_sram_addr_ok, 1'b1);
    tick(); inst_sram_req = 1'b0; arready = 1'b1; settle();
    chk32("prio arid inst", 32'(arid), 32'(ID_INST));
    chk32("prio araddr inst", araddr, 32'h1c000010);
    tick(); arready = 1'b0; rvalid = 1'b1; rid = ID_INST; rdata = 32'h11223344; settle();
    chk1("prio inst data_ok", inst_sram_data_ok, 1'b1);
    chk32("prio inst rdata", inst_sram_rdata, 32'h11223344);
    tick(); clear_inputs(); tick();

    // ---------------- data read blocked behind a write ----------------
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h1000;
    data_sram_size = 2'd2; data_sram_wstrb = 4'hf; data_sram_wdata = 32'h0badc0de;
    settle();
    chk1("raw write addr_ok", data_sram_addr_ok, 1'b1);
    tick(); data_sram_wr = 1'b0; awready = 1'b1; wready = 1'b1; settle();
    chk1("raw read blocked REQ", data_sram_addr_ok, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick(); awready = 1'b0; wready = 1'b0; settle();
      chk1("raw read blocked B", data_sram_addr_ok, 1'b0);
      chk1("raw bready", bready, 1'b1);
    end
    tick(); bvalid = 1'b1; settle();
    chk1("raw write data_ok", data_sram_data_ok, 1'b1);
    chk1("raw read blocked bvalid", data_sram_addr_ok, 1'b0);
    tick(); bvalid = 1'b0; settle();
    chk1("raw read accepted", data_sram_addr_ok, 1'b1);
    tick(); data_sram_req = 1'b0; arready = 1'b1; settle();
    chk32("raw araddr", araddr, 32'h1000);
    chk32("raw arid", 32'(arid), 32'(ID_DATA));
    tick(); arready = 1'b0; rvalid = 1'b1; rid = ID_DATA; rdata = 32'h0badc0de; settle();
    chk1("raw read data_ok", data_sram_data_ok, 1'b1);
    chk32("raw read rdata", data_sram_rdata, 32'h0badc0de);
    tick(); clear_inputs(); tick();

    // ---------------- inst read overlapping a data write ----------------
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1c000100; inst_sram_size = 2'd2;
    settle();
    chk1("ovl inst addr_ok", inst_sram_addr_ok, 1'b1);
    tick(); inst_sram_req = 1'b0;
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h2000;
    data_sram_wstrb = 4'h1; data_sram_wdata = 32'h77;
    settle();
    chk1("ovl arvalid", arvalid, 1'b1);
    chk1("ovl write addr_ok", data_sram_addr_ok, 1'b1);
    tick(); data_sram_req = 1'b0; arready = 1'b1; awready = 1'b1; wready = 1'b1; settle();
    chk1("ovl awvalid", awvalid, 1'b1);
    chk1("ovl wvalid", wvalid, 1'b1);
    tick(); arready = 1'b0; awready = 1'b0; wready = 1'b0;
    rvalid = 1'b1; rid = ID_INST; rdata = 32'h00c0ffee; bvalid = 1'b1;
    settle();
    chk1("ovl inst data_ok", inst_sram_data_ok, 1'b1);
    chk1("ovl data data_ok", data_sram_data_ok, 1'b1);
    chk32("ovl inst rdata", inst_sram_rdata, 32'h00c0ffee);
    tick(); rvalid = 1'b0; bvalid = 1'b0; settle();
    chk_quiet("ovl end");
    clear_inputs(); tick();

    // ---------------- reset while waiting for read data ----------------
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1c000200; inst_sram_size = 2'd2;
    tick(); inst_sram_req = 1'b0; arready = 1'b1;
    tick(); arready = 1'b0; settle();
    chk1("rst pre rready", rready, 1'b1);
    resetn = 1'b0;
    #1;
    chk1("rst async rready", rready, 1'b0);
    chk1("rst async arvalid", arvalid, 1'b0);
    tick(); resetn = 1'b1; rvalid = 1'b1; rid = ID_INST; rdata = 32'hbad0bad0; settle();
    chk1("rst post inst data_ok", inst_sram_data_ok, 1'b0);
    chk1("rst post data data_ok", data_sram_data_ok, 1'b0);
    chk1("rst post rready", rready, 1'b0);
    tick(); rvalid = 1'b0;
    run_txn(tbl[6]);
    clear_inputs(); tick();

    // ---------------- randomized concurrent traffic ----------------
    m_rd_busy = 0; m_ar_done = 0; m_wr_busy = 0; m_aw_done = 0; m_w_done = 0;
    m_rd_addr = '0; m_wr_addr = '0; m_wr_data = '0; m_rd_size = '0; m_wr_size = '0;
    m_rd_id = '0; m_wr_strb = '0;
    p_iok = 0; p_dok = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      tick();
      // core side: hold a request until it is accepted
      if (!(inst_sram_req && !p_iok)) begin
        inst_sram_req   = ($urandom_range(2, 0) == 0);
        inst_sram_wr    = 1'($urandom_range(1, 0));
        inst_sram_addr  = $urandom;
        inst_sram_size  = 2'($urandom_range(2, 0));
        inst_sram_wstrb = 4'($urandom);
        inst_sram_wdata = $urandom;
      end
      if (!(data_sram_req && !p_dok)) begin
        data_sram_req   = ($urandom_range(2, 0) == 0);
        data_sram_wr    = 1'($urandom_range(1, 0));
        data_sram_addr  = $urandom;
        data_sram_size  = 2'($urandom_range(2, 0));
        data_sram_wstrb = 4'($urandom);
        data_sram_wdata = $urandom;
      end
      // slave side
      arready = 1'($urandom_range(1, 0));
      rvalid  = m_rd_busy && m_ar_done && ($urandom_range(2, 0) == 0);
      rid     = ($urandom_range(7, 0) == 0) ? 4'hA : m_rd_id;
      rdata   = $urandom;
      awready = 1'($urandom_range(1, 0));
      wready  = 1'($urandom_range(1, 0));
      bvalid  = m_wr_busy && m_aw_done && m_w_done && ($urandom_range(2, 0) == 0);
      settle();

      e_arv = m_rd_busy && !m_ar_done;
      e_rr  = m_rd_busy && m_ar_done;
      e_awv = m_wr_busy && !m_aw_done;
      e_wv  = m_wr_busy && !m_w_done;
      e_br  = m_wr_busy && m_aw_done && m_w_done;
      e_drd = data_sram_req && !data_sram_wr && !m_rd_busy && !m_wr_busy;
      e_iok = inst_sram_req && !m_rd_busy && !e_drd;
      e_dwr = data_sram_req && data_sram_wr && !m_wr_busy && !(m_rd_busy && m_rd_id == ID_DATA);
      r_from_dat = rvalid && (rid == ID_DATA);

      chk1("rnd inst addr_ok", inst_sram_addr_ok, e_iok);
      chk1("rnd data addr_ok", data_sram_addr_ok, e_drd || e_dwr);
      chk1("rnd arvalid", arvalid, e_arv);
      chk1("rnd rready", rready, e_rr);
      chk1("rnd awvalid", awvalid, e_awv);
      chk1("rnd wvalid", wvalid, e_wv);
      chk1("rnd bready", bready, e_br);
      chk1("rnd inst data_ok", inst_sram_data_ok, rvalid && (rid == ID_INST));
      chk1("rnd data data_ok", data_sram_data_ok, r_from_dat || bvalid);
      if (e_arv) begin
        chk32("rnd araddr", araddr, m_rd_addr);
        chk32("rnd arsize/arid", {25'd0, arsize, arid}, {25'd0, m_rd_size, m_rd_id});
      end
      if (e_awv) begin
        chk32("rnd awaddr", awaddr, m_wr_addr);
        chk32("rnd awsize", 32'(awsize), 32'(m_wr_size));
      end
      if (e_wv) begin
        chk32("rnd wdata", wdata, m_wr_data);
        chk32("rnd wstrb", 32'(wstrb), 32'(m_wr_strb));
      end
      if (rvalid && rid == ID_INST) chk32("rnd inst rdata", inst_sram_rdata, rdata);
      if (r_from_dat) chk32("rnd data rdata", data_sram_rdata, rdata);

      // advance the model to the state after this clock edge
      if (e_arv && arready) m_ar_done = 1;
      if (rvalid) m_rd_busy = 0;
      if (e_awv && awready) m_aw_done = 1;
      if (e_wv && wready)   m_w_done = 1;
      if (bvalid) m_wr_busy = 0;
      if (e_drd || e_iok) begin
        m_rd_busy = 1; m_ar_done = 0;
        m_rd_addr = e_drd ? data_sram_addr : inst_sram_addr;
        m_rd_size = {1'b0, e_drd ? data_sram_size : inst_sram_size};
        m_rd_id   = e_drd ? ID_DATA : ID_INST;
      end
      if (e_dwr) begin
        m_wr_busy = 1; m_aw_done = 0; m_w_done = 0;
        m_wr_addr = data_sram_addr; m_wr_size = {1'b0, data_sram_size};
        m_wr_strb = data_sram_wstrb; m_wr_data = data_sram_wdata;
      end
      p_iok = e_iok;
      p_dok = e_drd || e_dwr;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
- Sits directly downstream of the CPU core; consumes its two SRAM-like request/addr_ok/data_ok interfaces (instruction, data) and drives a single AXI master port.
- Reads: at most one outstanding, data port has priority over instruction port.
- Writes: at most one outstanding, data port only.
- Constant AXI fields (len=0, burst=INCR, lock, cache, prot, wid, wlast=1) are tied off at top level and are not ports of this block.

Parameters:
ID_INST, 4'd0, arid used for instruction reads
ID_DATA, 4'd1, arid used for data reads

Ports:
clk  in  1  clock
resetn  in  1  active-low reset
inst_sram_req / data_sram_req  in  1  request valid
inst_sram_wr / data_sram_wr  in  1  1=write (inst_sram_wr ignored, treated 0)
inst_sram_size / data_sram_size  in  2  0=byte 1=half 2=word
inst_sram_addr / data_sram_addr  in  32  byte address
inst_sram_wstrb / data_sram_wstrb  in  4  byte enables (inst ignored)
inst_sram_wdata / data_sram_wdata  in  32  write data (inst ignored)
inst_sram_addr_ok / data_sram_addr_ok  out  1  request accepted this cycle
inst_sram_data_ok / data_sram_data_ok  out  1  one-cycle completion pulse
inst_sram_rdata / data_sram_rdata  out  32  read data, valid with data_ok
arid, araddr, arsize  out  4,32,3  read address
arvalid / arready  out/in  1  read address handshake
rid, rdata  in  4,32  read response
rvalid / rready  in/out  1  read data handshake
awaddr, awsize  out  32,3  write address
awvalid / awready  out/in  1  write address handshake
wdata, wstrb  out  32,4  write data
wvalid / wready  out/in  1  write data handshake
bvalid / bready  in/out  1  write response handshake

Behaviour:
Reset (asynchronous, active-low) behaviour:
- Both FSMs go to IDLE.
- arvalid, rready, awvalid, wvalid, bready, both addr_ok and both data_ok are 0.
- Address/data registers clear to 0.
- Reset mid-transaction abandons it; no data_ok is emitted.

Read FSM states: RD_IDLE, RD_AR, RD_R.
- RD_IDLE: data read wins if data_req & ~data_wr & (write FSM IDLE); else inst read if inst_req.
  - Winner's addr_ok = 1 combinationally (same cycle as req).
  - Latch addr, size ({1'b0,size}) and id.
  - Go to RD_AR.
- RD_AR: arvalid=1, registered fields stable. On arready, go to RD_R.
- RD_R: rready=1. On rvalid:
  - rdata passes through to the port selected by rid (ID_INST/ID_DATA), with that port's data_ok=1 for that cycle.
  - Return to RD_IDLE.
  - A new request may be accepted the following cycle, not the same cycle.
- rid not matching either ID: complete the transaction, no data_ok.

Write FSM states: WR_IDLE, WR_REQ, WR_B.
- WR_IDLE: on data_req & data_wr & (no data read outstanding, i.e. read FSM IDLE, or its latched id ≠ ID_DATA):
  - data_addr_ok=1.
  - Latch addr, size, wstrb, wdata.
  - Set aw_pend=w_pend=1; go to WR_REQ.
- WR_REQ: awvalid=aw_pend, wvalid=w_pend.
  - Each pend clears on its own handshake; both handshakes in the same cycle are legal.
  - When both are clear, go to WR_B.
- WR_B: bready=1. On bvalid: data_data_ok=1 for one cycle; go to WR_IDLE.

Ordering and priority:
- Data read is never accepted while a write is outstanding (RAW safety).
- Read and write FSMs otherwise run concurrently.
- If a read and a write complete in the same cycle, only data_data_ok from the write can fire, because an outstanding data read excludes a write. An inst read and a data write may both pulse in the same cycle.
- addr_ok is never asserted without req. At most one addr_ok per port per cycle.

Latency:
- Minimum read latency: addr_ok at cycle N, arvalid at N+1, data_ok at N+2 with zero-wait slave.
- Minimum write latency: data_ok at N+2.

Test Plan:
- Inst read 0x1c000000 accepted; slave holds arready low for 3 cycles, then returns rdata=0x02800C0C, rid=0 → inst_data_ok pulses once with that data; araddr held stable for all arvalid cycles.
- Inst and data reads both requested in the same cycle → data addr_ok first with arid=1; inst addr_ok only after the data read's rvalid.
- Data write addr=0x1000, wstrb=4'b0011, wdata=0x1234abcd; awready comes 2 cycles before wready → single data_data_ok after bvalid; awvalid drops on its handshake while wvalid stays high.
- Write outstanding; data read to 0x1000 requested → data addr_ok stays 0 until the cycle after bvalid; the read then returns the slave's value.
- Inst read outstanding while a data write is issued and completes; b and r arrive in the same cycle → both ports' data_ok=1 that cycle.
- resetn pulled low while in RD_R → arvalid/rready are 0 immediately (asynchronous); no data_ok after release; a fresh request is accepted normally.
